truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequential stimulus/capture stage that sits directly upstream of a 3-input combinational logic gate module (in1, in2, in3 -> out). It drives all 8 input combinations in order and holds each one for a programmable settle time. At the end of each hold it samples the gate output and assembles the 8-bit truth-table value, for example 8'hFF for a constant-1 gate. It then compares that value against an expected table and reports pass or fail.

Parameters:
SETTLE_CYCLES, 4, number of clock cycles each input combination is held before sampling; legal range 1..255, and 0 is illegal.
CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES-1.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a sweep; sampled only in IDLE.
abort  input  1  synchronous abort; returns the block to IDLE without asserting done.
expected  input  8  expected truth table; bit k is the expected output for {in1,in2,in3}==k; latched on start.
dut_out  input  1  output of the gate under test.
in1  output  1  gate input MSB (idx[2]).
in2  output  1  gate input (idx[1]).
in3  output  1  gate input LSB (idx[0]).
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
table_out  output  8  captured truth table; bit k = dut_out sampled while {in1,in2,in3}==k.
match  output  1  table_out == latched expected; valid from done onward.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE, idx=0, cnt=0;
  - in1/in2/in3=0, busy=0, done=0;
  - table_out=8'h00, match=0, expected latch=8'h00.
- Reset asserted mid-sweep aborts immediately to these values.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - in1..in3 = 0.
  - On start=1 (and abort=0) at an edge:
    - latch expected, clear table_out to 0, clear match;
    - idx=0, cnt=0, busy=1;
    - go to SWEEP.
- SWEEP:
  - {in1,in2,in3} = idx (registered outputs, change only on the idx update edge).
  - cnt increments every cycle.
  - At the edge where cnt==SETTLE_CYCLES-1:
    - table_out[idx] <= dut_out, cnt <= 0;
    - if idx==7, go to DONE; otherwise idx <= idx+1.
  - Each combination is therefore driven for exactly SETTLE_CYCLES cycles.
- DONE (one cycle):
  - done=1, busy=0;
  - match = (table_out == expected latch), registered on entry to DONE so it is valid in the done cycle;
  - in1..in3 return to 0;
  - next state IDLE.
  - table_out and match hold until the next accepted start or reset.
- Latency: start accepted at edge E0, done high during the cycle after edge E0 + 8*SETTLE_CYCLES, busy high for 8*SETTLE_CYCLES cycles.
- start while in SWEEP or DONE is ignored; it is not queued.
- start held continuously gives back-to-back sweeps, with one IDLE cycle between done and the next busy.
- abort=1 at any edge in SWEEP or DONE:
  - go to IDLE, in*=0, busy=0, done=0, match=0;
  - table_out retains its partially captured bits.
- abort has priority over start and over sampling at the same edge. abort in IDLE has no effect.
- dut_out is sampled as-is; no synchroniser is needed because the gate runs on the same clock domain.

Test Plan:
- SETTLE_CYCLES=4, dut_out tied 1, expected=8'hFF, start pulse -> in* walks 000..111 with 4 cycles each; done pulses exactly 33 cycles after the start edge; table_out=8'hFF, match=1.
- dut_out = in1&in2&in3, expected=8'h80 -> table_out=8'h80, match=1; rerun with expected=8'h81 -> match=0, table_out still 8'h80.
- dut_out = in1^in2^in3, SETTLE_CYCLES=1 -> table_out=8'h96, done 9 cycles after start, busy high for 8 cycles.
- start re-pulsed at the 10th cycle of a sweep -> ignored; a single done occurs; a start held high for 100 cycles with S=4 -> done pulses spaced 34 cycles apart.
- Constant-1 dut, abort asserted while idx=3 -> next cycle busy=0, in*=000, no done; table_out=8'h07; a subsequent start clears table_out and completes normally.
- rst_n deasserted asynchronously mid-sweep (between clock edges) -> all outputs immediately 0 and table_out=8'h00; after release, start runs a full sweep correctly.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Handshake and gate-facing signals of the truth-table sweeper.
// The slave modport is the sweeper's view; master is the controller/gate side.
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;

    modport master (
        output start, abort, expected, dut_out,
        input  in1, in2, in3, busy, done, table_out, match
    );

    modport slave (
        input  start, abort, expected, dut_out,
        output in1, in2, in3, busy, done, table_out, match
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 input combinations, holds each for
// SETTLE_CYCLES clocks, captures the output into a truth table and compares it.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       in_q;
    logic             busy_q;
    logic             done_q;
    logic             match_q;
    logic [7:0]       table_q;
    logic [7:0]       exp_q;
    logic [7:0]       table_next;

    // Table as it will look after this edge's sample, so match can be
    // registered in the same edge that enters DONE.
    always_comb begin
        table_next      = table_q;
        table_next[idx] = bus.dut_out;
    end

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            in_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            table_q <= '0;
            exp_q   <= '0;
        end else if (bus.abort && state != IDLE) begin
            // table_q deliberately keeps whatever bits were already captured.
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            in_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    in_q   <= '0;
                    if (bus.start) begin
                        exp_q   <= bus.expected;
                        table_q <= '0;
                        match_q <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST_CNT) begin
                        table_q <= table_next;
                        cnt     <= '0;
                        if (idx == 3'd7) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            in_q    <= '0;
                            match_q <= (table_next == exp_q);
                        end else begin
                            idx  <= idx + 3'd1;
                            in_q <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in1       = in_q[2];
    assign bus.in2       = in_q[1];
    assign bus.in3       = in_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at SETTLE_CYCLES=4,
// one at SETTLE_CYCLES=1, each driven by a behavioural gate model.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sweeper_if bus4 ();
    truth_table_sweeper_if bus1 ();

    truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Gate selector: 0 constant 1, 1 three-input AND, 2 three-input XOR.
    logic [1:0] sel4 = 2'd0;
    logic [1:0] sel1 = 2'd0;

    function automatic logic gate(input logic [1:0] sel, input logic a, input logic b, input logic c);
        case (sel)
            2'd1:    return a & b & c;
            2'd2:    return a ^ b ^ c;
            default: return 1'b1;
        endcase
    endfunction

    assign bus4.dut_out = gate(sel4, bus4.in1, bus4.in2, bus4.in3);
    assign bus1.dut_out = gate(sel1, bus1.in1, bus1.in2, bus1.in3);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [2:0] in4();
        return {bus4.in1, bus4.in2, bus4.in3};
    endfunction

    // Full sweep on the S=4 instance: start edge E0, sample n lies after E_n.
    task automatic sweep4(input logic [1:0] sel, input logic [7:0] exp_tbl,
                          input logic [7:0] want_tbl, input logic want_match);
        sel4 = sel;
        bus4.expected = exp_tbl;
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
        check("s4_table_cleared", 32'(bus4.table_out), 32'h00);
        check("s4_match_cleared", 32'(bus4.match), 32'd0);
        for (int n = 0; n < 32; n++) begin
            check("s4_in_walk", 32'(in4()), 32'(n / 4));
            check("s4_busy", 32'(bus4.busy), 32'd1);
            check("s4_no_done", 32'(bus4.done), 32'd0);
            cyc();
        end
        check("s4_done", 32'(bus4.done), 32'd1);
        check("s4_busy_low", 32'(bus4.busy), 32'd0);
        check("s4_in_zero", 32'(in4()), 32'd0);
        check("s4_table", 32'(bus4.table_out), 32'(want_tbl));
        check("s4_match", 32'(bus4.match), 32'(want_match));
        cyc();
        check("s4_done_pulse", 32'(bus4.done), 32'd0);
        check("s4_table_hold", 32'(bus4.table_out), 32'(want_tbl));
        check("s4_match_hold", 32'(bus4.match), 32'(want_match));
    endtask

    initial begin : stimulus
        int done_cnt;
        int first_done;
        int second_done;

        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.expected = 8'h00;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.expected = 8'h00;

        // Reset state
        cyc(); cyc();
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_done", 32'(bus4.done), 32'd0);
        check("rst_in", 32'(in4()), 32'd0);
        check("rst_table", 32'(bus4.table_out), 32'h00);
        check("rst_match", 32'(bus4.match), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Constant-1 gate, then AND gate with matching and non-matching expectations
        sweep4(2'd0, 8'hFF, 8'hFF, 1'b1);
        cyc();
        sweep4(2'd1, 8'h80, 8'h80, 1'b1);
        cyc();
        sweep4(2'd1, 8'h81, 8'h80, 1'b0);
        cyc();

        // XOR gate at SETTLE_CYCLES=1: busy 8 cycles, table 8'h96
        sel1 = 2'd2;
        bus1.expected = 8'h96;
        bus1.start = 1'b1;
        cyc();
        bus1.start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check("s1_in_walk", 32'({bus1.in1, bus1.in2, bus1.in3}), 32'(n));
            check("s1_busy", 32'(bus1.busy), 32'd1);
            check("s1_no_done", 32'(bus1.done), 32'd0);
            cyc();
        end
        check("s1_done", 32'(bus1.done), 32'd1);
        check("s1_busy_low", 32'(bus1.busy), 32'd0);
        check("s1_table", 32'(bus1.table_out), 32'h96);
        check("s1_match", 32'(bus1.match), 32'd1);
        cyc();

        // start re-pulsed mid-sweep is ignored
        sel4 = 2'd0;
        bus4.expected = 8'hFF;
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
        for (int n = 0; n < 9; n++) cyc();
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
        done_cnt = 0;
        first_done = -1;
        for (int n = 10; n < 80; n++) begin
            if (bus4.done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
            cyc();
        end
        check("restart_single_done", 32'(done_cnt), 32'd1);
        check("restart_done_time", 32'(first_done), 32'd32);
        check("restart_table", 32'(bus4.table_out), 32'hFF);

        // start held high for 100 cycles: done pulses 34 cycles apart
        bus4.start = 1'b1;
        cyc();
        done_cnt = 0;
        first_done = -1;
        second_done = -1;
        for (int n = 0; n < 100; n++) begin
            if (bus4.done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
            cyc();
        end
        bus4.start = 1'b0;
        cyc(); cyc();
        check("held_done_count", 32'(done_cnt), 32'd2);
        check("held_first_done", 32'(first_done), 32'd32);
        check("held_spacing", 32'(second_done - first_done), 32'd34);
        check("held_idle", 32'(bus4.busy), 32'd0);

        // abort while idx==3
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
        for (int n = 0; n < 13; n++) cyc();
        check("abort_pre_in", 32'(in4()), 32'd3);
        bus4.abort = 1'b1;
        cyc();
        bus4.abort = 1'b0;
        check("abort_busy", 32'(bus4.busy), 32'd0);
        check("abort_in", 32'(in4()), 32'd0);
        check("abort_done", 32'(bus4.done), 32'd0);
        check("abort_table", 32'(bus4.table_out), 32'h07);
        check("abort_match", 32'(bus4.match), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus4.done) done_cnt++;
            cyc();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        sweep4(2'd0, 8'hFF, 8'hFF, 1'b1);
        cyc();

        // Asynchronous reset mid-sweep, then a clean sweep
        bus4.start = 1'b1;
        cyc();
        bus4.start = 1'b0;
        for (int n = 0; n < 20; n++) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus4.busy), 32'd0);
        check("arst_in", 32'(in4()), 32'd0);
        check("arst_done", 32'(bus4.done), 32'd0);
        check("arst_table", 32'(bus4.table_out), 32'h00);
        check("arst_match", 32'(bus4.match), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        sweep4(2'd2, 8'h96, 8'h96, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
